// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_rx_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_IDX_W     = $clog2(UART_DATA_BITS);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } uart_rx_state_t;

  // States in which a frame is being received.
  function automatic logic state_is_running(input uart_rx_state_t s);
    return (s == START) || (s == DATA) || (s == STOP);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with start-glitch rejection, stop-bit check and a
// one-entry valid/ready output buffer that flags overrun.
module uart_rx_8n1
  import uart_rx_pkg::*;
#(
  parameter int unsigned UART_CLK_TICKS_PER_BIT = 65
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      uart_rx,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      rx_running,
  output logic                      framing_error,
  output logic                      overrun
);

  localparam int unsigned TICKS = UART_CLK_TICKS_PER_BIT;
  localparam int unsigned CNT_W = $clog2(TICKS);
  localparam int unsigned HALF  = TICKS >> 1;

  localparam logic [CNT_W-1:0]      CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TICKS - 1);
  localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t              state_q, state_nx;
  logic [CNT_W-1:0]            cnt_q, cnt_nx;
  logic [UART_IDX_W-1:0]       idx_q, idx_nx;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_nx;
  logic                        byte_done_c;
  logic                        frame_err_c;

  // Idle-high line: reset the synchronizer to the idle level.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (uart_rx),
    .q      (rx_s)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= WAIT_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state_q;
    cnt_nx      = cnt_q + CNT_W'(1);
    idx_nx      = idx_q;
    shift_nx    = shift_q;
    byte_done_c = 1'b0;
    frame_err_c = 1'b0;

    case (state_q)
      WAIT_IDLE: begin
        cnt_nx = '0;
        if (rx_s) state_nx = IDLE;
      end
      IDLE: begin
        cnt_nx = '0;
        if (!rx_s) begin
          state_nx = START;
          idx_nx   = '0;
        end
      end
      // Re-check the line at mid start bit to reject glitches.
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_nx   = '0;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_nx   = '0;
          shift_nx = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          idx_nx   = idx_q + UART_IDX_W'(1);
          if (idx_q == IDX_LAST) state_nx = STOP;
        end
      end
      // Leave at mid stop bit so a back-to-back start edge is not missed.
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            byte_done_c = 1'b1;
            state_nx    = IDLE;
          end else begin
            frame_err_c = 1'b1;
            state_nx    = WAIT_IDLE;
          end
        end
      end
      default: begin
        state_nx = WAIT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_nx;
      idx_q   <= idx_nx;
      shift_q <= shift_nx;
    end
  end

  // One-entry output buffer; a slot being consumed this cycle counts as free.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      rx_running    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_running    <= state_is_running(state_nx);
      framing_error <= frame_err_c;
      overrun       <= 1'b0;
      if (byte_done_c && (!data_valid || data_ready)) begin
        data_out   <= shift_q;
        data_valid <= 1'b1;
      end else begin
        if (data_valid && data_ready) data_valid <= 1'b0;
        if (byte_done_c)              overrun    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: frame-level timing model plus per-cycle output compare.
module tb_uart_rx_8n1;

  localparam int unsigned T    = 65;
  localparam int unsigned HALF = T / 2;
  localparam int unsigned MAXC = 60000;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       rx_running;
  logic       framing_error;
  logic       overrun;

  uart_rx_8n1 #(.UART_CLK_TICKS_PER_BIT(T)) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .rx_running    (rx_running),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk_in = ~clk_in;

  // Expected-behaviour timeline, indexed by clock edge number.
  int unsigned cyc = 0;
  bit          run_a   [MAXC];
  bit [1:0]    ev_kind [MAXC];   // 1: byte completes, 2: framing error
  bit [7:0]    ev_byte [MAXC];

  bit          m_valid = 1'b0;
  bit [7:0]    m_data  = 8'h00;
  bit          m_run   = 1'b0;
  bit          m_ferr  = 1'b0;
  bit          m_ovr   = 1'b0;

  int          n_chk = 0;
  int          n_pass = 0;
  bit          chk_en = 1'b0;
  bit          rand_ready = 1'b0;
  bit          prev_valid = 1'b0;
  int unsigned last_rise = 0;
  int          ferr_cnt = 0;
  int          ovr_cnt = 0;
  logic [7:0]  got_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // A falling edge driven after edge n is synchronized by edge n+2, so the
  // frame is "running" from edge n+3 until the mid-stop-bit sample completes.
  function automatic void schedule(input int unsigned n, input logic [7:0] b,
                                   input bit stop_ok, input bit glitch);
    int unsigned s;
    int unsigned dur;
    s   = n + 3;
    dur = glitch ? HALF : HALF + 9 * T;
    if (s + dur >= MAXC) begin
      $display("FAIL schedule: cycle %0d beyond model range %0d", s + dur, MAXC);
      $fatal(1);
    end
    for (int unsigned k = s; k < s + dur; k++) run_a[k] = 1'b1;
    if (!glitch) begin
      ev_kind[s + dur] = stop_ok ? 2'd1 : 2'd2;
      ev_byte[s + dur] = b;
    end
  endfunction

  // Reference model: advances at every edge using the inputs seen at that edge.
  always @(posedge clk_in) begin
    cyc    = cyc + 1;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (cyc < MAXC) begin
      if (reset) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_run   = 1'b0;
        for (int unsigned k = cyc; k < MAXC; k++) begin
          run_a[k]   = 1'b0;
          ev_kind[k] = 2'd0;
        end
      end else begin
        if (m_valid && data_ready) m_valid = 1'b0;
        if (ev_kind[cyc] == 2'd1) begin
          if (!m_valid) begin
            m_valid = 1'b1;
            m_data  = ev_byte[cyc];
          end else begin
            m_ovr = 1'b1;
          end
        end else if (ev_kind[cyc] == 2'd2) begin
          m_ferr = 1'b1;
        end
        m_run = run_a[cyc];
      end
    end
  end

  // Per-cycle compare and delivery monitor, away from the active edge.
  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("data_valid",    {31'd0, data_valid},    {31'd0, m_valid});
      chk("data_out",      {24'd0, data_out},      {24'd0, m_data});
      chk("rx_running",    {31'd0, rx_running},    {31'd0, m_run});
      chk("framing_error", {31'd0, framing_error}, {31'd0, m_ferr});
      chk("overrun",       {31'd0, overrun},       {31'd0, m_ovr});
      if (data_valid && data_ready) got_q.push_back(data_out);
      if (framing_error) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (data_valid && !prev_valid) last_rise = cyc;
      prev_valid = data_valid;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (rand_ready) data_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  // Drives one frame; cut != 0 stops driving after that many cycles.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int unsigned cut);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    schedule(cyc, b, stop_ok, 1'b0);
    for (int c = 0; c < 10 * T; c++) begin
      if (cut != 0 && c == int'(cut)) return;
      uart_rx = bits[c / T];
      tick();
    end
  endtask

  task automatic glitch(input int unsigned len);
    schedule(cyc, 8'h00, 1'b0, 1'b1);
    uart_rx = 1'b0;
    idle(len);
    uart_rx = 1'b1;
    idle(HALF + 5);
  endtask

  initial begin
    #(MAXC * 10 - 100);
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned n0;
    int q0, f0, o0;
    string s;
    logic [7:0] b;
    int unsigned r;
    bit ok;

    reset = 1'b1; uart_rx = 1'b1; data_ready = 1'b1;
    tick();
    chk_en = 1'b1;
    idle(2);
    chk("rst_data_out",  {24'd0, data_out}, 32'h00);
    chk("rst_valid",     {31'd0, data_valid}, 32'd0);
    chk("rst_running",   {31'd0, rx_running}, 32'd0);
    chk("rst_ferr",      {31'd0, framing_error}, 32'd0);
    chk("rst_overrun",   {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    idle(10);

    // Single byte and its latency from line edge to data_valid.
    n0 = cyc; q0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h55, 1'b1, 0);
    idle(20);
    chk("single_latency", last_rise - n0, 32'd620);
    chk("single_count",   got_q.size() - q0, 32'd1);
    chk("single_byte",    {24'd0, got_q[q0]}, 32'h55);
    chk("single_errors",  (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);

    // Start-bit glitch.
    q0 = got_q.size();
    glitch(20);
    chk("glitch_running", {31'd0, rx_running}, 32'd0);
    chk("glitch_nobyte",  got_q.size() - q0, 32'd0);

    // Framing error, line kept low afterwards.
    q0 = got_q.size(); f0 = ferr_cnt;
    send_frame(8'hA3, 1'b0, 0);
    idle(200);
    chk("ferr_held_idle", {31'd0, rx_running}, 32'd0);
    uart_rx = 1'b1;
    idle(10);
    chk("ferr_count",  ferr_cnt - f0, 32'd1);
    chk("ferr_nobyte", got_q.size() - q0, 32'd0);

    // Overrun with consumer stalled.
    data_ready = 1'b0; o0 = ovr_cnt;
    send_frame(8'h4C, 1'b1, 0);
    send_frame(8'h2D, 1'b1, 0);
    idle(10);
    chk("ovr_data",  {24'd0, data_out}, 32'h4C);
    chk("ovr_valid", {31'd0, data_valid}, 32'd1);
    chk("ovr_count", ovr_cnt - o0, 32'd1);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk("ovr_drain", {31'd0, data_valid}, 32'd0);
    idle(5);

    // Reset during data bit 4.
    data_ready = 1'b1; q0 = got_q.size();
    send_frame(8'hB6, 1'b1, 5 * T + T / 2);
    uart_rx = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_data_out", {24'd0, data_out}, 32'h00);
    chk("rstmid_valid",    {31'd0, data_valid}, 32'd0);
    chk("rstmid_running",  {31'd0, rx_running}, 32'd0);
    idle(12 * T);
    chk("rstmid_nobyte", got_q.size() - q0, 32'd0);

    // Line low throughout reset, then a clean frame.
    q0 = got_q.size();
    uart_rx = 1'b0; reset = 1'b1;
    idle(4);
    reset = 1'b0; uart_rx = 1'b1;
    idle(10);
    chk("rstlow_nobyte", got_q.size() - q0, 32'd0);
    send_frame(8'h31, 1'b1, 0);
    idle(20);
    chk("rstlow_count", got_q.size() - q0, 32'd1);
    chk("rstlow_byte",  {24'd0, got_q[q0]}, 32'h31);

    // Back-to-back stream.
    s = "brR L-7766";
    q0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
    for (int i = 0; i < 10; i++) send_frame(s[i], 1'b1, 0);
    idle(20);
    chk("stream_count",  got_q.size() - q0, 32'd10);
    chk("stream_errors", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);
    for (int i = 0; i < 10; i++) chk("stream_byte", {24'd0, got_q[q0 + i]}, {24'd0, s[i]});

    // Randomized frames, glitches, bad stops and consumer stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        glitch($urandom_range(1, HALF - 2));
      end else begin
        b  = 8'($urandom);
        ok = (r != 1);
        send_frame(b, ok, 0);
        uart_rx = 1'b1;
        idle(ok ? $urandom_range(0, 30) : $urandom_range(2, 30));
      end
    end
    rand_ready = 1'b0;
    data_ready = 1'b1;
    idle(30);
    chk("rand_drained", {31'd0, data_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

Serial byte receiver that sits directly upstream of the command decoder in `control_module`. It turns the host picture/video UART line into framed bytes for that decoder. It receives 8N1 frames at a fixed tick-per-bit rate, with start-bit glitch rejection and stop-bit checking. Each received byte is held in a one-entry valid/ready output buffer that reports overrun.

## Interface
- `UART_CLK_TICKS_PER_BIT`, default 7'd65: clock cycles per bit (16 MHz / 246154 baud). Must be ≥ 4. Counter width is `$clog2(UART_CLK_TICKS_PER_BIT)`.
- `clk_in`, input, 1 bit: single clock for all logic.
- `reset`, input, 1 bit: synchronous, active-high.
- `uart_rx`, input, 1 bit: asynchronous serial line, idle high.
- `data_out`, output, 8 bits: received byte. Valid while `data_valid` is high.
- `data_valid`, output, 1 bit: output buffer holds an unconsumed byte.
- `data_ready`, input, 1 bit: consumer accepts the byte on a cycle where `data_valid && data_ready`.
- `rx_running`, output, 1 bit: high in `START`, `DATA` and `STOP`.
- `framing_error`, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `overrun`, output, 1 bit: one-cycle pulse when a completed byte is dropped because the buffer is full.

## Operation
- **Input synchronizer:** `uart_rx` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rx_s`.
- **FSM states:** `WAIT_IDLE`, `IDLE`, `START`, `DATA`, `STOP`.
  - `WAIT_IDLE`: stay until `rx_s == 1`, then go to `IDLE`. This is the reset state, so a line held low through reset is never taken as a start bit.
  - `IDLE`: if `rx_s == 0`, go to `START` and clear the tick counter and bit index.
  - `START`: count to `HALF-1`, where `HALF = UART_CLK_TICKS_PER_BIT >> 1`. At that count, if `rx_s == 0` go to `DATA` with the counter cleared. Otherwise the start bit was a glitch: return to `IDLE` with no pulse.
  - `DATA`: count to `UART_CLK_TICKS_PER_BIT-1`, then sample `rx_s` into the shift register, LSB first, and clear the counter. After bit index 7, go to `STOP`.
  - `STOP`: count to `UART_CLK_TICKS_PER_BIT-1`, then sample.
    - If the sample is 1: present the byte to the output buffer and go to `IDLE`.
    - If the sample is 0: pulse `framing_error`, discard the byte and go to `WAIT_IDLE`.
- **Output buffer:**
  - **Empty, or being consumed this cycle** (`data_valid && data_ready`): a completed byte loads `data_out` and `data_valid` is 1 next cycle. If the old byte is accepted in the same cycle a new one completes, `data_valid` stays high with the new value.
  - **Full and not consumed this cycle:** the new byte is dropped, `data_out` is unchanged, and `overrun` pulses.
  - **Consume with no new byte:** `data_valid` clears next cycle.
- **Reset mid-frame:** state goes to `WAIT_IDLE` and the partial byte is lost. The buffer clears, and any byte held in it is also lost.

## Timing
- **Reset values:** `data_out` = 8'h00; `data_valid`, `rx_running`, `framing_error`, `overrun` = 0.
- **Synchronizer latency:** 2 cycles from a `uart_rx` edge to `rx_s`.
- **Sample point:** measured from the first cycle in `START`, the stop bit is sampled `HALF + 9*UART_CLK_TICKS_PER_BIT - 1` cycles later (616 at the default).
- **Output:** `data_valid` rises, or `framing_error`/`overrun` pulses, on the following cycle. All outputs are registered.
- **Back-to-back frames:** a start bit arriving immediately after the stop bit is detected, because `STOP` exits at mid-stop-bit.
- **Tolerance:** the receiver tolerates ±2% baud mismatch.

## Structure
- **Package `uart_rx_pkg`:** `typedef enum logic [2:0] uart_rx_state_t`, holding the five states.
- **Sub-module `sync_2ff`:** a generic 2-flop synchronizer with a reset-value parameter. It is natural to split out and reuse for other async inputs.

## Test plan
- **Single byte:** send 8'h55 at 65 ticks/bit with `data_ready = 1` → one `data_valid` cycle with `data_out == 8'h55`, latency as in Timing, and no error pulses.
- **Glitch rejection:** a low pulse of 20 cycles on the idle line → no `START`-to-`DATA` transition, `rx_running` back low within 34 cycles, no outputs.
- **Framing error:** send 8'hA3 with the stop bit low, then hold the line low for 200 cycles → `framing_error` pulses once, `data_valid` stays 0, no new frame starts until the line returns high.
- **Overrun:** `data_ready = 0`, send 8'h4C then 8'h2D back-to-back → `data_out == 8'h4C` held, `overrun` pulses once. Then raise `data_ready` for one cycle → `data_valid` drops.
- **Reset mid-frame and while held low:**
  - Assert `reset` for 1 cycle during bit 4 of a frame → all outputs 0, no byte delivered.
  - Hold the line low through reset → no byte delivered until a high is seen; the next clean frame 8'h31 is received correctly.
- **Stream:** send the ASCII string `"brR L-7766"`, 10 bytes with no inter-frame gap, with `data_ready = 1` → all 10 bytes delivered in order, zero errors.
